// File: rtl/la_counter_pkg.sv
// Shared LA bit map, status output map and GPIO layout for the LA-driven counter probe.
// Pure constants; no logic, no latency, no backpressure.
package la_counter_pkg;
  localparam int LA_W        = 128;
  localparam int LA_LOAD_LO  = 0;
  localparam int LA_CMP_LO   = 32;
  localparam int LA_STB_LOAD = 64;
  localparam int LA_EN       = 65;
  localparam int LA_DIR      = 66;
  localparam int LA_STB_SNAP = 67;
  localparam int LA_STB_CLR  = 68;
  localparam int LA_PRESC_LO = 72;

  localparam int OUT_COUNT_LO = 0;
  localparam int OUT_SNAP_LO  = 32;
  localparam int OUT_MATCH    = 64;
  localparam int OUT_OVF      = 65;
  localparam int OUT_EN       = 66;

  localparam int IRQ_W     = 3;
  localparam int IO_W      = 38;
  localparam int IO_RSVD   = 8;
endpackage

// File: rtl/la_edge_detect.sv
// Gated LA strobe rise detector: one registered pulse one edge after the rising sample.
// No backpressure; a level held high fires exactly once, including across reset release.
module la_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic oenb,
  output logic pulse
);
  logic gated;
  logic prev;

  assign gated = din & ~oenb;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= gated;
      pulse <= gated & ~prev;
    end
  end
endmodule

// File: rtl/la_counter_probe.sv
// Prescaled up/down counter with load, compare-match, wrap and snapshot, controlled from LA probes.
// Controls register once, act on the next edge; outputs are flops; no backpressure.
module la_counter_probe
  import la_counter_pkg::*;
#(
  parameter int COUNT_W = 32,
  parameter int PRESC_W = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [LA_W-1:0]   la_data_in,
  input  logic [LA_W-1:0]   la_oenb,
  output logic [LA_W-1:0]   la_data_out,
  output logic [IO_W-1:0]   io_out,
  output logic [IO_W-1:0]   io_oeb,
  output logic [IRQ_W-1:0]  irq
);
  logic [COUNT_W-1:0] load_in, cmp_in;
  logic [PRESC_W-1:0] presc_in;
  logic               en_in, dir_in;

  // A multi-bit field is only trusted when the SoC drives every bit of it.
  assign load_in  = (la_oenb[LA_LOAD_LO +: COUNT_W] == '0) ? la_data_in[LA_LOAD_LO +: COUNT_W] : '0;
  assign cmp_in   = (la_oenb[LA_CMP_LO +: COUNT_W] == '0) ? la_data_in[LA_CMP_LO +: COUNT_W] : '0;
  assign presc_in = (la_oenb[LA_PRESC_LO +: PRESC_W] == '0) ? la_data_in[LA_PRESC_LO +: PRESC_W] : '0;
  assign en_in    = la_data_in[LA_EN] & ~la_oenb[LA_EN];
  assign dir_in   = la_data_in[LA_DIR] & ~la_oenb[LA_DIR];

  logic load_stb, snap_stb, clr_stb;

  la_edge_detect u_stb_load (.clk(wb_clk_i), .rst(wb_rst_i), .din(la_data_in[LA_STB_LOAD]),
                             .oenb(la_oenb[LA_STB_LOAD]), .pulse(load_stb));
  la_edge_detect u_stb_snap (.clk(wb_clk_i), .rst(wb_rst_i), .din(la_data_in[LA_STB_SNAP]),
                             .oenb(la_oenb[LA_STB_SNAP]), .pulse(snap_stb));
  la_edge_detect u_stb_clr  (.clk(wb_clk_i), .rst(wb_rst_i), .din(la_data_in[LA_STB_CLR]),
                             .oenb(la_oenb[LA_STB_CLR]), .pulse(clr_stb));

  logic [COUNT_W-1:0] load_q, cmp_q, count, snap, count_nxt;
  logic [PRESC_W-1:0] presc_lim_q, presc, presc_nxt;
  logic               en_q, dir_q, match, ovf, irq_match, irq_wrap;
  logic               tick, wrap, hit;

  always_comb begin
    tick      = 1'b0;
    wrap      = 1'b0;
    count_nxt = count;
    presc_nxt = presc;
    if (en_q) begin
      if (presc == presc_lim_q) begin
        tick      = 1'b1;
        presc_nxt = '0;
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end
    // Load pre-empts a coincident tick entirely, including its wrap.
    if (load_stb) begin
      count_nxt = load_q;
      presc_nxt = '0;
    end else if (tick) begin
      count_nxt = dir_q ? count - 1'b1 : count + 1'b1;
      wrap      = dir_q ? (count == '0) : (count == '1);
    end
    hit = (load_stb | tick) && (count_nxt == cmp_q);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      load_q      <= '0;
      cmp_q       <= '0;
      presc_lim_q <= '0;
      en_q        <= 1'b0;
      dir_q       <= 1'b0;
      count       <= '0;
      presc       <= '0;
      snap        <= '0;
      match       <= 1'b0;
      ovf         <= 1'b0;
      irq_match   <= 1'b0;
      irq_wrap    <= 1'b0;
    end else begin
      load_q      <= load_in;
      cmp_q       <= cmp_in;
      presc_lim_q <= presc_in;
      en_q        <= en_in;
      dir_q       <= dir_in;
      count       <= count_nxt;
      presc       <= presc_nxt;
      if (snap_stb) snap <= count;
      match       <= hit | (match & ~clr_stb);
      ovf         <= wrap | (ovf & ~clr_stb);
      irq_match   <= hit;
      irq_wrap    <= wrap;
    end
  end

  always_comb begin
    la_data_out = '0;
    la_data_out[OUT_COUNT_LO +: COUNT_W] = count;
    la_data_out[OUT_SNAP_LO +: COUNT_W]  = snap;
    la_data_out[OUT_MATCH] = match;
    la_data_out[OUT_OVF]   = ovf;
    la_data_out[OUT_EN]    = en_q;
  end

  assign io_out = {count[IO_W-IO_RSVD-1:0], {IO_RSVD{1'b0}}};
  assign io_oeb = {{(IO_W-IO_RSVD){1'b0}}, {IO_RSVD{1'b1}}};
  assign irq    = {1'b0, irq_wrap, irq_match};

  logic unused_bits;
  assign unused_bits = ^{la_data_in[LA_W-1:LA_PRESC_LO+PRESC_W], la_data_in[LA_PRESC_LO-1:LA_STB_CLR+1],
                         la_oenb[LA_W-1:LA_PRESC_LO+PRESC_W], la_oenb[LA_PRESC_LO-1:LA_STB_CLR+1],
                         count[COUNT_W-1:IO_W-IO_RSVD]};
endmodule
